// File: rtl/pulse_stretch_mc.sv
// Multi-channel event stretcher: each rising edge is replayed as a STRETCH_CYC pulse plus a GAP_CYC low gap.
// Latency is 1 cycle from rise to stretch_out/toggle_out; there is no backpressure, and excess events queue in a saturating counter.
module pulse_stretch_mc #(
  parameter int NUM_CH      = 4,
  parameter int STRETCH_CYC = 4,
  parameter int GAP_CYC     = 2,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pulse_in,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic [NUM_CH-1:0] stretch_out,
  output logic [NUM_CH-1:0] toggle_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] ovf_sticky
);
  localparam int               CNT_MAX  = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int               TW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [TW-1:0]    HI_LAST  = TW'(STRETCH_CYC - 1);
  localparam logic [TW-1:0]    GAP_LAST = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam bit               HAS_GAP  = (GAP_CYC > 0);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic [TW-1:0]    cnt;
    logic [CNT_W-1:0] pending;
    logic             prev_q;
    logic             stretch_q;
    logic             toggle_q;
    logic             ovf_q;
    logic             rise;
    logic             last;
    logic             start_pt;
    logic             go;
    logic             drop;

    assign rise = pulse_in[i] & ~prev_q;
    assign last = (cnt == '0);
    // Without a gap the last HIGH cycle doubles as a start point, merging back-to-back pulses.
    assign start_pt = (state == S_IDLE) ||
                      (last && ((state == S_GAP) || (state == S_HIGH && !HAS_GAP)));
    assign go   = start_pt && ((pending != '0) || rise);
    assign drop = !start_pt && rise && (pending == PEND_MAX);

    always_ff @(posedge clk) begin
      prev_q <= pulse_in[i];
      if (rst) begin
        state     <= S_IDLE;
        cnt       <= '0;
        pending   <= '0;
        stretch_q <= 1'b0;
        toggle_q  <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        if (go) begin
          state     <= S_HIGH;
          cnt       <= HI_LAST;
          stretch_q <= 1'b1;
          toggle_q  <= ~toggle_q;
        end else if (start_pt) begin
          state     <= S_IDLE;
          cnt       <= '0;
          stretch_q <= 1'b0;
        end else if (state == S_HIGH && last) begin
          state     <= S_GAP;
          cnt       <= GAP_LAST;
          stretch_q <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end

        // A pop and a simultaneous rise cancel, so a start never overflows.
        if (start_pt && (pending != '0)) begin
          if (!rise) pending <= pending - 1'b1;
        end else if (!start_pt && rise && !drop) begin
          pending <= pending + 1'b1;
        end

        if (drop) ovf_q <= 1'b1;
        else if (ovf_clr[i]) ovf_q <= 1'b0;
      end
    end

    assign stretch_out[i] = stretch_q;
    assign toggle_out[i]  = toggle_q;
    assign ovf_sticky[i]  = ovf_q;
    assign busy[i]        = (state != S_IDLE) || (pending != '0);
  end

endmodule
